// File: rtl/led_display_scheduler_pkg.sv
// Shared definitions for the LED display scheduler: FSM encoding, display
// width, default dwell time and an index-width helper.
package led_display_scheduler_pkg;

   localparam int unsigned DISP_W        = 16;
   localparam int unsigned DWELL_DEFAULT = 50_000_000;
   localparam int unsigned CNT_W         = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first set request at or after start, wrapping, so the
// slot just before start is examined last.
module rr_arbiter
   import led_display_scheduler_pkg::*;
#(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = sel_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   // Outer loop walks priority order; inner loop finds the slot at that offset.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int unsigned off = 0; off < N; off++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (!any && req[j] && (((j + N - 32'(start)) % N) == off)) begin
               any     = 1'b1;
               gnt[j]  = 1'b1;
               gnt_idx = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/led_display_scheduler.sv
// Time-shares one 16-bit LED display among NUM_SRC requesters: rotates
// round-robin every DWELL_CYCLES, refreshes the shown word, supports pinning.
module led_display_scheduler
   import led_display_scheduler_pkg::*;
#(
   parameter  int unsigned NUM_SRC      = 4,
   parameter  int unsigned DWELL_CYCLES = DWELL_DEFAULT,
   localparam int unsigned SEL_W        = sel_width(NUM_SRC)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*DISP_W-1:0]   src_data,
   output logic [NUM_SRC-1:0]          src_ack,
   input  logic                        pin_en,
   input  logic [SEL_W-1:0]            pin_sel,
   output logic [DISP_W-1:0]           value,
   output logic [SEL_W-1:0]            cur_src,
   output logic                        value_valid
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pin_q;
   logic               cap_en, cap_arb;
   logic [SEL_W-1:0]   cap_idx, nxt_src, arb_start, arb_idx;
   logic [NUM_SRC-1:0] arb_gnt, ack_d;
   logic               arb_any, cur_valid, pin_hit;
   logic [DISP_W-1:0]  value_d;

   // Request bits of the displayed and pinned sources; out-of-range pin_sel never hits.
   always_comb begin
      cur_valid = 1'b0;
      pin_hit   = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (cur_src == SEL_W'(i)) cur_valid = src_valid[i];
         if (pin_sel == SEL_W'(i)) pin_hit   = src_valid[i];
      end
   end

   assign nxt_src   = (cur_src == SEL_W'(NUM_SRC - 1)) ? '0 : cur_src + SEL_W'(1);
   assign arb_start = (state_q == ST_IDLE) ? '0 : nxt_src;

   rr_arbiter #(.N(NUM_SRC)) u_arb (
      .req     (src_valid),
      .start   (arb_start),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next state, dwell counter and capture decision.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_en  = 1'b0;
      cap_arb = 1'b0;
      cap_idx = cur_src;
      if (pin_en) begin
         if (pin_hit) begin
            cap_en  = 1'b1;
            cap_idx = pin_sel;
            state_d = ST_SHOW;
            cnt_d   = RELOAD;
         end
      end else if (pin_q && (state_q != ST_IDLE)) begin
         // Leaving pinned mode restarts a full dwell on the shown source.
         state_d = ST_SHOW;
         cnt_d   = RELOAD;
         cap_en  = cur_valid;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (arb_any) begin
                  cap_en  = 1'b1;
                  cap_arb = 1'b1;
                  cap_idx = arb_idx;
                  state_d = ST_SHOW;
                  cnt_d   = RELOAD;
               end
            end
            ST_SHOW: begin
               if (cnt_q == '0) begin
                  if (arb_any) begin
                     cap_en  = 1'b1;
                     cap_arb = 1'b1;
                     cap_idx = arb_idx;
                     cnt_d   = RELOAD;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  cnt_d  = cnt_q - CNT_W'(1);
                  cap_en = cur_valid;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Captured word and the single ack bit for this edge.
   always_comb begin
      ack_d   = '0;
      value_d = value;
      if (cap_en) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (cap_idx == SEL_W'(i)) begin
               value_d  = src_data[i*DISP_W +: DISP_W];
               ack_d[i] = !cap_arb;
            end
         end
         if (cap_arb) ack_d = arb_gnt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         pin_q       <= 1'b0;
         value       <= '0;
         cur_src     <= '0;
         src_ack     <= '0;
         value_valid <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pin_q   <= pin_en;
         value   <= value_d;
         src_ack <= ack_d;
         if (cap_en) begin
            cur_src     <= cap_idx;
            value_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_led_display_scheduler.sv
// Scoreboard bench for led_display_scheduler (NUM_SRC=4, DWELL_CYCLES=4):
// stimulus queues expected captures, a negedge monitor checks each ack.
module tb_led_display_scheduler;

   typedef struct packed {
      logic [3:0]  ack;
      logic [15:0] val;
      logic [1:0]  idx;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  src_valid;
   logic [63:0] src_data;
   logic [3:0]  src_ack;
   logic        pin_en;
   logic [1:0]  pin_sel;
   logic [15:0] value;
   logic [1:0]  cur_src;
   logic        value_valid;

   logic [15:0] data [4];
   exp_t        sb_q [$];
   int          n_cmp = 0;
   int          n_err = 0;

   assign src_data = {data[3], data[2], data[1], data[0]};

   led_display_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ack     (src_ack),
      .pin_en      (pin_en),
      .pin_sel     (pin_sel),
      .value       (value),
      .cur_src     (cur_src),
      .value_valid (value_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] ack2idx(input logic [3:0] a);
      case (a)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Drive one cycle of inputs; eack != 0 means a capture is expected at the next edge.
   task automatic step(input logic [3:0] v, input logic pe, input logic [1:0] ps,
                       input logic [3:0] eack);
      exp_t e;
      src_valid = v;
      pin_en    = pe;
      pin_sel   = ps;
      if (eack != 4'b0000) begin
         e.ack = eack;
         e.idx = ack2idx(eack);
         e.val = data[e.idx];
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(sb_q.size()), 32'd0);
      rst       = 1'b0;
      src_valid = '0;
      pin_en    = 1'b0;
      pin_sel   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Monitor: every captured word is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && src_ack !== 4'b0000) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_ack: got %b expected none at %0t", src_ack, $time);
            end else begin
               e = sb_q.pop_front();
               chk("ack",     32'(src_ack), 32'(e.ack));
               chk("value",   32'(value),   32'(e.val));
               chk("cur_src", 32'(cur_src), 32'(e.idx));
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      src_valid = '0;
      pin_en    = 1'b0;
      pin_sel   = '0;
      for (int i = 0; i < 4; i++) data[i] = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_value",       32'(value),       32'h0);
      chk("rst_cur_src",     32'(cur_src),     32'h0);
      chk("rst_ack",         32'(src_ack),     32'h0);
      chk("rst_value_valid", 32'(value_valid), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Rotation between sources 1 and 2 with refresh acks during each dwell.
      data[1] = 16'h1111;
      data[2] = 16'h2222;
      for (int k = 0; k < 12; k++)
         step(4'b0110, 1'b0, 2'd0, (((k / 4) % 2) == 0) ? 4'b0010 : 4'b0100);
      chk("value_valid_set", 32'(value_valid), 32'h1);

      // Single request from source 3, then dwell expiry into HOLD.
      do_reset();
      data[3] = 16'hBEEF;
      step(4'b1000, 1'b0, 2'd0, 4'b1000);
      repeat (6) step(4'b0000, 1'b0, 2'd0, 4'b0000);
      chk("hold_value",   32'(value),   32'hBEEF);
      chk("hold_cur_src", 32'(cur_src), 32'h3);
      // From HOLD a new request is taken at once.
      data[0] = 16'h0A0A;
      step(4'b0001, 1'b0, 2'd0, 4'b0001);

      // Mid-dwell refresh of source 0 must not stretch the dwell.
      step(4'b0100, 1'b0, 2'd0, 4'b0000);
      data[0] = 16'h00A5;
      step(4'b0101, 1'b0, 2'd0, 4'b0001);
      step(4'b0100, 1'b0, 2'd0, 4'b0000);
      step(4'b0100, 1'b0, 2'd0, 4'b0100);
      chk("dwell_end_value", 32'(value), 32'h2222);

      // Pinned to source 2 with everyone requesting, then released.
      repeat (5) step(4'b1111, 1'b1, 2'd2, 4'b0100);
      repeat (4) step(4'b1111, 1'b0, 2'd0, 4'b0100);
      step(4'b1111, 1'b0, 2'd0, 4'b1000);
      chk("unpin_value", 32'(value), 32'hBEEF);

      // Pinned to a source that is not requesting: nothing changes.
      repeat (3) step(4'b0001, 1'b1, 2'd3, 4'b0000);
      chk("pin_idle_value",   32'(value),   32'hBEEF);
      chk("pin_idle_cur_src", 32'(cur_src), 32'h3);

      // Asynchronous reset in the middle of a dwell.
      do_reset();
      data[0] = 16'h1234;
      step(4'b0001, 1'b0, 2'd0, 4'b0001);
      step(4'b0000, 1'b0, 2'd0, 4'b0000);
      chk("pre_areset_value", 32'(value), 32'h1234);
      data[0]   = 16'h5555;
      src_valid = 4'b0001;
      #2 rst = 1'b0;
      #1;
      chk("areset_value",       32'(value),       32'h0);
      chk("areset_value_valid", 32'(value_valid), 32'h0);
      chk("areset_ack",         32'(src_ack),     32'h0);
      chk("areset_cur_src",     32'(cur_src),     32'h0);
      @(negedge clk);
      #1;
      chk("areset_ack_hold", 32'(src_ack), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_edge_ack",   32'(src_ack), 32'h0);
      chk("rst_edge_value", 32'(value),   32'h0);
      #1;
      begin
         exp_t e;
         e.ack = 4'b0001;
         e.idx = 2'd0;
         e.val = 16'h5555;
         sb_q.push_back(e);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_value_valid", 32'(value_valid), 32'h1);
      @(negedge clk);
      #1;
      chk("final_queue_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
